sequenciador_pc: RTL and testbench
==================================

// Module: sequenciador_pc
// PURPOSE
//  Next-PC controller for the MIPS datapath. Owns the PC register and sequences the
//  branch-target adder (pc+4 + sinal_shift) and the jump-target path.
//  Enforces one architectural delay slot and redirects to the exception vector.
//  Feeds the instruction-memory address and the EPC to the control unit.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  EXC_VECTOR  32'h0000_0080  PC loaded when excecao is accepted
// PORTS
//  clock         in   1   rising-edge clock
//  reset         in   1   asynchronous, active-high reset
//  stall         in   1   freeze PC, FSM and latched target this cycle
//  branch_req    in   1   current instr (at pc) is a conditional branch
//  branch_taken  in   1   branch condition result; valid with branch_req
//  sinal_shift   in   32  sign-extended offset already <<2; bits[1:0] ignored (forced 0)
//  jump_req      in   1   current instr (at pc) is J/JAL
//  jump_alvo     in   26  instr_index field of the jump
//  excecao       in   1   exception raised by the instr at pc
//  pc            out  32  current fetch address (registered)
//  pc_mais4      out  32  pc + 4 (combinational)
//  alvo_branch   out  32  pc_mais4 + {sinal_shift[31:2],2'b00} (combinational)
//  epc           out  32  address of the faulting instruction (registered)
//  delay_slot    out  1   1 while pc points to a delay-slot instruction (registered)
//  estado        out  2   FSM state: 0 BUSCA, 1 DESVIO, 2 EXCECAO
// BEHAVIOUR
//  Reset (async, immediate):
//   - pc=RESET_PC, epc=0, delay_slot=0, estado=BUSCA, latched target=0.
//  Arithmetic:
//   - All adds are 32-bit modulo.
//   - 32'hFFFF_FFFC + 4 wraps to 0; there is no overflow flag.
//   - Jump target = {pc_mais4[31:28], jump_alvo, 2'b00}.
//  Per-edge priority (highest first): excecao > stall > FSM action.
//  excecao=1 (any state, even with stall=1):
//   - epc<=pc, pc<=EXC_VECTOR, delay_slot<=0, estado<=EXCECAO.
//   - Any pending redirect is discarded.
//  stall=1 (no excecao): pc, epc, delay_slot, estado and the latched target all hold.
//  BUSCA:
//   - jump_req=1: latch jump target, pc<=pc_mais4, delay_slot<=1, ->DESVIO.
//     Jump wins if branch_req is also 1.
//   - branch_req & branch_taken: latch alvo_branch, pc<=pc_mais4, delay_slot<=1, ->DESVIO.
//   - Otherwise, or branch not taken: pc<=pc_mais4, delay_slot<=0, stay BUSCA.
//  DESVIO (pc is the delay-slot instr):
//   - pc<=latched target, delay_slot<=0, ->BUSCA.
//   - branch_req/jump_req in this state are ignored (branch in a delay slot is unsupported).
//  EXCECAO:
//   - One cycle at EXC_VECTOR, then pc<=pc_mais4, ->BUSCA.
//   - Requests are handled as in BUSCA on the following edge.
//  Latency: a taken branch/jump reaches pc exactly 2 unstalled edges after it is presented.
//  Stall in DESVIO delays the redirect but does not lose it.
//  Reset mid-DESVIO cancels the redirect; pc=RESET_PC.
// TESTING
//  1 Reset: assert reset with pc at 0x40 mid-run.
//    -> pc=0, epc=0, estado=0 without waiting for a clock edge.
//  2 Sequential fetch, 4 edges, no requests -> pc 0,4,8,C,10; delay_slot stays 0.
//  3 Branch at pc=0x10, taken, sinal_shift=0x20 -> alvo_branch=0x34.
//    Next edge pc=0x14 with delay_slot=1; next edge pc=0x34 with estado=0.
//  4 Branch at 0x10, sinal_shift=0xFFFF_FFF0 (-16), 1-cycle stall in DESVIO
//    -> pc 0x14, 0x14 (held), then 0x04.
//  5 Jump at pc=0x1000_0008, jump_alvo=0x100 -> pc 0x1000_000C, then 0x1000_0400.
//    Simultaneous branch_req=1 is ignored.
//  6 excecao with stall=1 at pc=0x14 (in DESVIO, target 0x34)
//    -> epc=0x14, pc=0x80, estado=2, then pc=0x84; 0x34 is never fetched.

Source files
------------

// File: rtl/sequenciador_pc.sv
// sequenciador_pc: next-PC controller with PC register, one delay slot and an exception redirect.
module sequenciador_pc #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_req,
    input  logic        branch_taken,
    input  logic [31:0] sinal_shift,
    input  logic        jump_req,
    input  logic [25:0] jump_alvo,
    input  logic        excecao,
    output logic [31:0] pc,
    output logic [31:0] pc_mais4,
    output logic [31:0] alvo_branch,
    output logic [31:0] epc,
    output logic        delay_slot,
    output logic [1:0]  estado
);
    localparam logic [1:0] BUSCA   = 2'd0;
    localparam logic [1:0] DESVIO  = 2'd1;
    localparam logic [1:0] EXCECAO = 2'd2;
    logic [31:0] pc_q, pc_d, epc_q, epc_d, alvo_q, alvo_d, alvo_jump;
    logic [1:0]  estado_q, estado_d;
    logic        ds_q, ds_d, redirect;
    assign pc_mais4    = pc_q + 32'd4;
    assign alvo_branch = pc_mais4 + {sinal_shift[31:2], 2'b00};
    assign alvo_jump   = {pc_mais4[31:28], jump_alvo, 2'b00};
    assign redirect    = jump_req | (branch_req & branch_taken);
    assign pc          = pc_q;
    assign epc         = epc_q;
    assign delay_slot  = ds_q;
    assign estado      = estado_q;
    always_comb begin
        pc_d     = pc_q;
        epc_d    = epc_q;
        ds_d     = ds_q;
        estado_d = estado_q;
        alvo_d   = alvo_q;
        if (excecao) begin
            epc_d    = pc_q;
            pc_d     = EXC_VECTOR;
            ds_d     = 1'b0;
            estado_d = EXCECAO;
        end else if (!stall) begin
            if (estado_q == DESVIO) begin
                pc_d     = alvo_q;
                ds_d     = 1'b0;
                estado_d = BUSCA;
            end else begin
                // EXCECAO and BUSCA fetch identically; requests in the vector slot are honoured
                pc_d     = pc_mais4;
                ds_d     = redirect;
                estado_d = redirect ? DESVIO : BUSCA;
                alvo_d   = jump_req ? alvo_jump : redirect ? alvo_branch : alvo_q;
            end
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            epc_q    <= '0;
            ds_q     <= 1'b0;
            estado_q <= BUSCA;
            alvo_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            ds_q     <= ds_d;
            estado_q <= estado_d;
            alvo_q   <= alvo_d;
        end
    end
endmodule

// File: tb/tb_sequenciador_pc.sv
// tb_sequenciador_pc: directed self-checking bench for sequenciador_pc.
module tb_sequenciador_pc;
    logic        clock = 0, reset = 1, stall = 0, branch_req = 0, branch_taken = 0, jump_req = 0, excecao = 0;
    logic [31:0] sinal_shift = 0;
    logic [25:0] jump_alvo = 0;
    logic [31:0] pc, pc_mais4, alvo_branch, epc;
    logic        delay_slot;
    logic [1:0]  estado;
    int total = 0, bad = 0;

    sequenciador_pc dut (
        .clock(clock), .reset(reset), .stall(stall), .branch_req(branch_req),
        .branch_taken(branch_taken), .sinal_shift(sinal_shift), .jump_req(jump_req),
        .jump_alvo(jump_alvo), .excecao(excecao), .pc(pc), .pc_mais4(pc_mais4),
        .alvo_branch(alvo_branch), .epc(epc), .delay_slot(delay_slot), .estado(estado)
    );

    always #5 clock = ~clock;

    task step;
        @(posedge clock);
        #1;
    endtask

    task clear_in;
        stall = 0; branch_req = 0; branch_taken = 0; jump_req = 0; excecao = 0;
        sinal_shift = 0; jump_alvo = 0;
    endtask

    task restart(input int n);
        clear_in();
        reset = 1;
        step();
        reset = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task test_seq;
        logic [31:0] exp_pc;
        restart(0);
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL seq_start pc got %h exp 0", pc); end
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) begin branch_req = 1; branch_taken = 0; sinal_shift = 32'h100; end
            step();
            branch_req = 0;
            exp_pc = 32'(i * 4);
            total++; if (pc !== exp_pc || delay_slot !== 1'b0 || estado !== 2'd0) begin bad++; $display("FAIL seq_%0d pc=%h ds=%b st=%0d exp pc=%h ds=0 st=0", i, pc, delay_slot, estado, exp_pc); end
        end
    endtask

    task test_branch;
        branch_req = 1; branch_taken = 1; sinal_shift = 32'h20;
        #1;
        total++; if (alvo_branch !== 32'h34) begin bad++; $display("FAIL br_alvo got %h exp 34", alvo_branch); end
        step();
        clear_in();
        total++; if (pc !== 32'h14 || delay_slot !== 1'b1 || estado !== 2'd1) begin bad++; $display("FAIL br_slot pc=%h ds=%b st=%0d exp 14/1/1", pc, delay_slot, estado); end
        step();
        total++; if (pc !== 32'h34 || delay_slot !== 1'b0 || estado !== 2'd0) begin bad++; $display("FAIL br_target pc=%h ds=%b st=%0d exp 34/0/0", pc, delay_slot, estado); end
    endtask

    task test_stall;
        restart(4);
        branch_req = 1; branch_taken = 1; sinal_shift = 32'hFFFF_FFF0;
        step();
        clear_in();
        total++; if (pc !== 32'h14) begin bad++; $display("FAIL stall_slot pc got %h exp 14", pc); end
        stall = 1;
        step();
        stall = 0;
        total++; if (pc !== 32'h14 || estado !== 2'd1 || delay_slot !== 1'b1) begin bad++; $display("FAIL stall_hold pc=%h st=%0d ds=%b exp 14/1/1", pc, estado, delay_slot); end
        step();
        total++; if (pc !== 32'h04 || estado !== 2'd0) begin bad++; $display("FAIL stall_target pc=%h st=%0d exp 04/0", pc, estado); end
    endtask

    task test_jump;
        branch_req = 1; branch_taken = 1; sinal_shift = 32'h0FFF_FFFC;
        step();
        clear_in();
        step();
        total++; if (pc !== 32'h1000_0004) begin bad++; $display("FAIL jmp_setup pc got %h exp 10000004", pc); end
        step();
        jump_req = 1; jump_alvo = 26'h100; branch_req = 1; branch_taken = 1; sinal_shift = 32'h40;
        step();
        clear_in();
        total++; if (pc !== 32'h1000_000C || delay_slot !== 1'b1) begin bad++; $display("FAIL jmp_slot pc=%h ds=%b exp 1000000c/1", pc, delay_slot); end
        step();
        total++; if (pc !== 32'h1000_0400 || estado !== 2'd0) begin bad++; $display("FAIL jmp_target pc=%h st=%0d exp 10000400/0", pc, estado); end
    endtask

    task test_exc;
        restart(4);
        branch_req = 1; branch_taken = 1; sinal_shift = 32'h20;
        step();
        clear_in();
        excecao = 1; stall = 1;
        step();
        clear_in();
        total++; if (epc !== 32'h14 || pc !== 32'h80 || estado !== 2'd2 || delay_slot !== 1'b0) begin bad++; $display("FAIL exc_take epc=%h pc=%h st=%0d ds=%b exp 14/80/2/0", epc, pc, estado, delay_slot); end
        step();
        total++; if (pc !== 32'h84 || estado !== 2'd0 || epc !== 32'h14) begin bad++; $display("FAIL exc_resume pc=%h st=%0d epc=%h exp 84/0/14", pc, estado, epc); end
    endtask

    task test_reset;
        branch_req = 1; branch_taken = 1; sinal_shift = 32'hFFFF_FFB8;
        step();
        clear_in();
        step();
        total++; if (pc !== 32'h40) begin bad++; $display("FAIL rst_setup pc got %h exp 40", pc); end
        #2 reset = 1;
        #1;
        total++; if (pc !== 32'h0 || epc !== 32'h0 || estado !== 2'd0 || delay_slot !== 1'b0) begin bad++; $display("FAIL rst_async pc=%h epc=%h st=%0d ds=%b exp 0/0/0/0", pc, epc, estado, delay_slot); end
    endtask

    task test_wrap;
        restart(0);
        branch_req = 1; branch_taken = 1; sinal_shift = 32'hFFFF_FFF8;
        step();
        clear_in();
        step();
        total++; if (pc !== 32'hFFFF_FFFC || pc_mais4 !== 32'h0) begin bad++; $display("FAIL wrap_top pc=%h pc4=%h exp fffffffc/0", pc, pc_mais4); end
        step();
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_zero pc got %h exp 0", pc); end
    endtask

    initial begin
        test_seq();
        test_branch();
        test_stall();
        test_jump();
        test_exc();
        test_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
